plane_sweep_ctrl: RTL

PLANE_SWEEP_CTRL -- requirements
Module: plane_sweep_ctrl

---
 rtl/plane_sweep_pkg.sv | 19 +
 rtl/plane_sweep_ctrl_if.sv | 28 ++
 rtl/plane_sweep_ctrl_mod_norm.sv | 35 +++
 rtl/plane_sweep_ctrl.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/plane_sweep_pkg.sv
// Shared state encoding and default geometry for the plane sweep controller.
package plane_sweep_pkg;

  localparam int N_DEF      = 5;
  localparam int K_DEF      = 3;
  localparam int ROUNDS_DEF = 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INIT  = 3'd1,
    S_NORM  = 3'd2,
    S_READ  = 3'd3,
    S_OP    = 3'd4,
    S_WRITE = 3'd5,
    S_NEXT  = 3'd6,
    S_DONE  = 3'd7
  } state_e;

endpackage

// File: rtl/plane_sweep_ctrl_if.sv
// Handshake and memory-strobe bundle between the sweep controller (master) and its environment (slave).
interface plane_sweep_ctrl_if #(
  parameter int AW = 5,
  parameter int RW = 1
);

  logic          start;
  logic          dp_ready;
  logic          busy;
  logic          done;
  logic          mem_rd;
  logic          mem_wr;
  logic [AW-1:0] src_addr;
  logic [AW-1:0] dst_addr;
  logic          alu_en;
  logic [RW-1:0] round_idx;

  modport master (
    input  start, dp_ready,
    output busy, done, mem_rd, mem_wr, src_addr, dst_addr, alu_en, round_idx
  );

  modport slave (
    output start, dp_ready,
    input  busy, done, mem_rd, mem_wr, src_addr, dst_addr, alu_en, round_idx
  );

endinterface

// File: rtl/plane_sweep_ctrl_mod_norm.sv
// Iterative modular normaliser: adds N once per cycle until the loaded offset is non-negative.
module mod_norm #(
  parameter int N  = 5,
  parameter int TW = 6,
  parameter int XW = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic signed [TW-1:0] load_val,
  output logic                 busy,
  output logic        [XW-1:0] result
);

  localparam logic signed [TW-1:0] N_S = TW'(N);

  logic signed [TW-1:0] t_r;

  // Offset register: load wins, otherwise one +N correction while negative.
  always_ff @(posedge clk) begin
    if (rst) begin
      t_r <= '0;
    end else if (load) begin
      t_r <= load_val;
    end else if (t_r[TW-1]) begin
      t_r <= t_r + N_S;
    end else begin
      t_r <= t_r;
    end
  end

  assign busy   = t_r[TW-1];
  assign result = t_r[XW-1:0];

endmodule

// File: rtl/plane_sweep_ctrl.sv
// Plane sweep controller: visits every element of an N x N array, reading column (x - K*y) mod N.
// Defining PLANE_SWEEP_ROUNDS_EN enables ROUNDS repeated sweeps; otherwise a single sweep runs.
module plane_sweep_ctrl
  import plane_sweep_pkg::*;
#(
  parameter int N      = N_DEF,
  parameter int K      = K_DEF,
  parameter int ROUNDS = ROUNDS_DEF
) (
  input  logic               clk,
  input  logic               rst,
  plane_sweep_ctrl_if.master bus
);

  localparam int AW = $clog2(N * N);
  localparam int RW = $clog2(ROUNDS + 1);
  localparam int XW = $clog2(N);
  localparam int TW = $clog2((K + 1) * N + 1) + 1;

  localparam logic        [XW-1:0] X_LAST = XW'(N - 1);
  localparam logic signed [TW-1:0] K_S    = TW'(K);

  state_e               state_r, state_nxt;
  logic        [XW-1:0] x_r, x_nxt, y_r, y_nxt, xs_r, xs_nxt;
  logic        [RW-1:0] round_r, round_nxt;
  logic        [AW-1:0] src_r, src_nxt, dst_r, dst_nxt;
  logic                 busy_r, done_r, rd_r, wr_r, alu_r;
  logic                 norm_load_s, norm_busy_s, last_round_s;
  logic        [XW-1:0] norm_res_s;
  logic signed [TW-1:0] t_init_s;

  // Raw source column offset; negative for most rows until normalised.
  assign t_init_s = $signed(TW'(x_r)) - K_S * $signed(TW'(y_r));

  mod_norm #(.N(N), .TW(TW), .XW(XW)) u_norm (
    .clk      (clk),
    .rst      (rst),
    .load     (norm_load_s),
    .load_val (t_init_s),
    .busy     (norm_busy_s),
    .result   (norm_res_s)
  );

`ifdef PLANE_SWEEP_ROUNDS_EN
  assign last_round_s  = (round_r == RW'(ROUNDS - 1));
  assign bus.round_idx = round_r;
`else
  assign last_round_s  = 1'b1;
  assign bus.round_idx = '0;
`endif

  // Next-state, position counters and address capture on entry to READ.
  always_comb begin
    state_nxt   = state_r;
    x_nxt       = x_r;
    y_nxt       = y_r;
    xs_nxt      = xs_r;
    round_nxt   = round_r;
    src_nxt     = src_r;
    dst_nxt     = dst_r;
    norm_load_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          state_nxt = S_INIT;
          x_nxt     = '0;
          y_nxt     = '0;
          round_nxt = '0;
        end else begin
          state_nxt = S_IDLE;
        end
      end
      S_INIT: begin
        norm_load_s = 1'b1;
        state_nxt   = S_NORM;
      end
      S_NORM: begin
        if (norm_busy_s) begin
          state_nxt = S_NORM;
        end else begin
          xs_nxt    = norm_res_s;
          src_nxt   = AW'(y_r) * AW'(N) + AW'(norm_res_s);
          dst_nxt   = AW'(y_r) * AW'(N) + AW'(x_r);
          state_nxt = S_READ;
        end
      end
      S_READ:  state_nxt = S_OP;
      S_OP: begin
        if (bus.dp_ready) begin
          state_nxt = S_WRITE;
        end else begin
          state_nxt = S_OP;
        end
      end
      S_WRITE: state_nxt = S_NEXT;
      S_NEXT: begin
        state_nxt = S_INIT;
        if (x_r == X_LAST) begin
          x_nxt = '0;
          if (y_r == X_LAST) begin
            y_nxt = '0;
            if (last_round_s) begin
              state_nxt = S_DONE;
            end else begin
              round_nxt = round_r + RW'(1);
            end
          end else begin
            y_nxt = y_r + XW'(1);
          end
        end else begin
          x_nxt = x_r + XW'(1);
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, counters and outputs are all registered from the next-state decode.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= S_IDLE;
      x_r     <= '0;
      y_r     <= '0;
      xs_r    <= '0;
      round_r <= '0;
      src_r   <= '0;
      dst_r   <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      rd_r    <= 1'b0;
      wr_r    <= 1'b0;
      alu_r   <= 1'b0;
    end else begin
      state_r <= state_nxt;
      x_r     <= x_nxt;
      y_r     <= y_nxt;
      xs_r    <= xs_nxt;
      round_r <= round_nxt;
      src_r   <= src_nxt;
      dst_r   <= dst_nxt;
      busy_r  <= (state_nxt != S_IDLE) && (state_nxt != S_DONE);
      done_r  <= (state_nxt == S_DONE);
      rd_r    <= (state_nxt == S_READ);
      wr_r    <= (state_nxt == S_WRITE);
      alu_r   <= (state_nxt == S_OP);
    end
  end

  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.mem_rd   = rd_r;
  assign bus.mem_wr   = wr_r;
  assign bus.alu_en   = alu_r;
  assign bus.src_addr = src_r;
  assign bus.dst_addr = dst_r;

endmodule
